// File: rtl/ppu_vram_arb.sv
// ppu_vram_arb: shares one synchronous VRAM port between the render fetch sequencer and the CPU data port.
// Optional macro PPU_ARB_RENDER_LOCK_EN holds off CPU grants while i_render_active is high.
module ppu_vram_arb #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_render_active,
    input  logic              i_render_req,
    input  logic [ADDR_W-1:0] i_render_addr,
    output logic              o_render_ack,
    output logic [DATA_W-1:0] o_render_rdata,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_wait,
    output logic              o_vram_en,
    output logic              o_vram_we,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [DATA_W-1:0] o_vram_wdata,
    input  logic [DATA_W-1:0] i_vram_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic              r_own_cpu;
    logic              r_we;
    logic              r_render_ack;
    logic              r_cpu_ack;
    logic              r_cpu_wait;
    logic              r_vram_en;
    logic              r_vram_we;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [DATA_W-1:0] r_vram_wdata;
    logic [DATA_W-1:0] r_render_rdata;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic w_sample;
    logic w_cpu_allowed;
    logic w_render_grant;
    logic w_cpu_grant;
    logic w_cpu_busy;

    assign w_sample = (r_state == S_IDLE) || (r_state == S_DONE);

`ifdef PPU_ARB_RENDER_LOCK_EN
    assign w_cpu_allowed = ~i_render_active;
`else
    logic w_unused_render_active;
    assign w_unused_render_active = i_render_active;
    assign w_cpu_allowed          = 1'b1;
`endif

    assign w_render_grant = w_sample & i_render_req;
    assign w_cpu_grant    = w_sample & i_cpu_req & ~i_render_req & w_cpu_allowed;
    // CPU already owns the port; its DONE cycle follows WAIT, so wait stays low through the ack.
    assign w_cpu_busy     = r_own_cpu & ((r_state == S_ISSUE) || (r_state == S_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_own_cpu      <= 1'b0;
            r_we           <= 1'b0;
            r_render_ack   <= 1'b0;
            r_cpu_ack      <= 1'b0;
            r_cpu_wait     <= 1'b0;
            r_vram_en      <= 1'b0;
            r_vram_we      <= 1'b0;
            r_vram_addr    <= '0;
            r_vram_wdata   <= '0;
            r_render_rdata <= '0;
            r_cpu_rdata    <= '0;
        end else begin
            r_vram_en    <= 1'b0;
            r_vram_we    <= 1'b0;
            r_render_ack <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_cpu_wait   <= i_cpu_req & ~w_cpu_grant & ~w_cpu_busy;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_render_grant || w_cpu_grant) begin
                        r_state     <= S_ISSUE;
                        r_own_cpu   <= w_cpu_grant;
                        r_we        <= w_cpu_grant & i_cpu_we;
                        r_vram_en   <= 1'b1;
                        r_vram_we   <= w_cpu_grant & i_cpu_we;
                        r_vram_addr <= w_cpu_grant ? i_cpu_addr : i_render_addr;
                        if (w_cpu_grant) begin
                            r_vram_wdata <= i_cpu_wdata;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    r_state <= S_DONE;
                    if (r_own_cpu) begin
                        r_cpu_ack <= 1'b1;
                        if (!r_we) begin
                            r_cpu_rdata <= i_vram_rdata;
                        end
                    end else begin
                        r_render_ack   <= 1'b1;
                        r_render_rdata <= i_vram_rdata;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_render_ack   = r_render_ack;
    assign o_render_rdata = r_render_rdata;
    assign o_cpu_ack      = r_cpu_ack;
    assign o_cpu_rdata    = r_cpu_rdata;
    assign o_cpu_wait     = r_cpu_wait;
    assign o_vram_en      = r_vram_en;
    assign o_vram_we      = r_vram_we;
    assign o_vram_addr    = r_vram_addr;
    assign o_vram_wdata   = r_vram_wdata;

endmodule

// File: tb/tb_ppu_vram_arb.sv
// tb_ppu_vram_arb: scoreboard bench for ppu_vram_arb with a VRAM model and a reference memory.
// Honours PPU_ARB_RENDER_LOCK_EN when the design is built with it.
module tb_ppu_vram_arb;

    typedef struct packed {
        logic       we;
        logic [7:0] data;
    } cpu_exp_t;

    logic        clk;
    logic        rst;
    logic        render_active;
    logic        render_req;
    logic [13:0] render_addr;
    logic        render_ack;
    logic [7:0]  render_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic        vram_en;
    logic        vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;

    logic [7:0]  mem     [0:16383];
    logic [7:0]  ref_mem [0:16383];
    logic [7:0]  render_q[$];
    cpu_exp_t    cpu_q[$];
    logic [7:0]  last_rd;
    logic        prev_en;

    int checks = 0;
    int errors = 0;

    ppu_vram_arb #(.ADDR_W(14), .DATA_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_render_active (render_active),
        .i_render_req    (render_req),
        .i_render_addr   (render_addr),
        .o_render_ack    (render_ack),
        .o_render_rdata  (render_rdata),
        .i_cpu_req       (cpu_req),
        .i_cpu_we        (cpu_we),
        .i_cpu_addr      (cpu_addr),
        .i_cpu_wdata     (cpu_wdata),
        .o_cpu_ack       (cpu_ack),
        .o_cpu_rdata     (cpu_rdata),
        .o_cpu_wait      (cpu_wait),
        .o_vram_en       (vram_en),
        .o_vram_we       (vram_we),
        .o_vram_addr     (vram_addr),
        .o_vram_wdata    (vram_wdata),
        .i_vram_rdata    (vram_rdata)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Synchronous VRAM: read data appears the clock after the strobe.
    always @(posedge clk) begin
        if (vram_en) begin
            if (vram_we) mem[vram_addr] = vram_wdata;
            else         vram_rdata <= mem[vram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_render_ack(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!render_ack && lat < 30);
        chk("render_ack_seen", 32'(render_ack), 32'd1);
    endtask

    task automatic wait_cpu_ack(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!cpu_ack && lat < 40);
        chk("cpu_ack_seen", 32'(cpu_ack), 32'd1);
    endtask

    // Render fetches: at most one new request per 4-clock slot.
    task automatic render_stream(input int n, input bit rnd_gap);
        for (int k = 0; k < n; k++) begin
            int          lat;
            logic [13:0] a;
            a = 14'($urandom_range(0, 32'h1FFF));
            render_addr = a;
            render_req  = 1'b1;
            render_q.push_back(ref_mem[a]);
            wait_render_ack(lat);
            render_req = 1'b0;
            chk("render_latency_le5", 32'(lat <= 5), 32'd1);
            for (int w = lat; w < 4; w++) step();
            if (rnd_gap) repeat ($urandom_range(0, 3)) step();
        end
    endtask

    task automatic cpu_issue(input logic we, input logic [13:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_we    = we;
        cpu_wdata = d;
        cpu_req   = 1'b1;
        if (we) begin
            cpu_q.push_back('{we: 1'b1, data: last_rd});
            ref_mem[a] = d;
        end else begin
            last_rd = ref_mem[a];
            cpu_q.push_back('{we: 1'b0, data: last_rd});
        end
    endtask

    task automatic cpu_stream(input int n);
        for (int k = 0; k < n; k++) begin
            int lat;
            cpu_issue(1'($urandom_range(0, 1)), 14'(32'h2000 + $urandom_range(0, 32'h1FFF)),
                      8'($urandom));
            wait_cpu_ack(lat);
            cpu_req = 1'b0;
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_render_ack"},   32'(render_ack),   32'd0);
        chk({tag, "_cpu_ack"},      32'(cpu_ack),      32'd0);
        chk({tag, "_cpu_wait"},     32'(cpu_wait),     32'd0);
        chk({tag, "_vram_en"},      32'(vram_en),      32'd0);
        chk({tag, "_vram_we"},      32'(vram_we),      32'd0);
        chk({tag, "_vram_addr"},    32'(vram_addr),    32'd0);
        chk({tag, "_vram_wdata"},   32'(vram_wdata),   32'd0);
        chk({tag, "_render_rdata"}, 32'(render_rdata), 32'd0);
        chk({tag, "_cpu_rdata"},    32'(cpu_rdata),    32'd0);
    endtask

    // Monitor: pops expectations whenever an ack is presented.
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
        end else begin
            if (vram_en) chk("vram_en_single_cycle", 32'(prev_en), 32'd0);
            prev_en = vram_en;
            if (render_ack) begin
                chk("ack_exclusive", 32'(cpu_ack), 32'd0);
                if (render_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL render_unexpected_ack: got ack with no request outstanding at %0t", $time);
                end else begin
                    logic [7:0] e;
                    e = render_q.pop_front();
                    chk("render_rdata", 32'(render_rdata), 32'(e));
                end
            end
            if (cpu_ack) begin
                chk("cpu_wait_at_ack", 32'(cpu_wait), 32'd0);
                if (cpu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cpu_unexpected_ack: got ack with no request outstanding at %0t", $time);
                end else begin
                    cpu_exp_t e;
                    e = cpu_q.pop_front();
                    chk(e.we ? "cpu_rdata_hold_on_write" : "cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        for (int i = 0; i < 16384; i++) begin
            ref_mem[i] = 8'($urandom);
            mem[i]     = ref_mem[i];
        end
        last_rd       = 8'h00;
        prev_en       = 1'b0;
        vram_rdata    = 8'h00;
        rst           = 1'b1;
        render_active = 1'b0;
        render_req    = 1'b0;
        render_addr   = '0;
        cpu_req       = 1'b0;
        cpu_we        = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;

        // Render read of 0x2000
        mem[14'h2000]     = 8'h5A;
        ref_mem[14'h2000] = 8'h5A;
        render_addr = 14'h2000;
        render_req  = 1'b1;
        render_q.push_back(8'h5A);
        step();
        chk("t1_vram_en",   32'(vram_en),   32'd1);
        chk("t1_vram_we",   32'(vram_we),   32'd0);
        chk("t1_vram_addr", 32'(vram_addr), 32'h2000);
        step();
        chk("t1_vram_en_off", 32'(vram_en),    32'd0);
        chk("t1_no_ack_yet",  32'(render_ack), 32'd0);
        step();
        chk("t1_render_ack",   32'(render_ack),   32'd1);
        chk("t1_render_rdata", 32'(render_rdata), 32'h5A);
        chk("t1_cpu_ack_low",  32'(cpu_ack),      32'd0);
        render_req = 1'b0;
        step();
        chk("t1_ack_one_cycle", 32'(render_ack), 32'd0);

        // CPU write 0xC3 to 0x3F00 then read back
        cpu_issue(1'b1, 14'h3F00, 8'hC3);
        step();
        chk("t2_vram_en",    32'(vram_en),    32'd1);
        chk("t2_vram_we",    32'(vram_we),    32'd1);
        chk("t2_vram_addr",  32'(vram_addr),  32'h3F00);
        chk("t2_vram_wdata", 32'(vram_wdata), 32'hC3);
        step();
        step();
        chk("t2_cpu_ack_write", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        step();
        cpu_issue(1'b0, 14'h3F00, 8'h00);
        wait_cpu_ack(lat);
        chk("t2_read_latency", 32'(lat), 32'd3);
        chk("t2_cpu_rdata",    32'(cpu_rdata), 32'hC3);
        cpu_req = 1'b0;
        step();

        // Simultaneous requests: render first, CPU regranted in render DONE
        render_addr = 14'h0100;
        render_req  = 1'b1;
        render_q.push_back(ref_mem[14'h0100]);
        cpu_issue(1'b0, 14'h2000, 8'h00);
        step();
        chk("t3_render_first", 32'(vram_addr), 32'h0100);
        chk("t3_wait_issue",   32'(cpu_wait),  32'd1);
        step();
        chk("t3_wait_wait",    32'(cpu_wait),  32'd1);
        step();
        chk("t3_render_ack",   32'(render_ack), 32'd1);
        chk("t3_wait_done",    32'(cpu_wait),   32'd1);
        render_req = 1'b0;
        step();
        chk("t3_cpu_issue_en",   32'(vram_en),   32'd1);
        chk("t3_cpu_issue_addr", 32'(vram_addr), 32'h2000);
        chk("t3_wait_cleared",   32'(cpu_wait),  32'd0);
        step();
        step();
        chk("t3_cpu_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        step();

        // Address change after grant must not disturb the in-flight access
        mem[14'h0000] = 8'h11;  ref_mem[14'h0000] = 8'h11;
        mem[14'h0010] = 8'h22;  ref_mem[14'h0010] = 8'h22;
        render_addr = 14'h0000;
        render_req  = 1'b1;
        render_q.push_back(8'h11);
        step();
        render_addr = 14'h0010;
        chk("t4_addr_latched", 32'(vram_addr), 32'h0000);
        step();
        chk("t4_addr_held", 32'(vram_addr), 32'h0000);
        step();
        chk("t4_render_rdata", 32'(render_rdata), 32'h11);
        render_req = 1'b0;
        step();

        // Reset during WAIT of a CPU read, then re-present
        cpu_addr  = 14'h3F00;
        cpu_we    = 1'b0;
        cpu_req   = 1'b1;
        step();
        chk("t5_issue", 32'(vram_en), 32'd1);
        step();
        rst = 1'b1;
        step();
        chk_all_zero("t5_midreset");
        rst     = 1'b0;
        last_rd = 8'h00;
        cpu_issue(1'b0, 14'h3F00, 8'h00);
        wait_cpu_ack(lat);
        chk("t5_reissue_latency", 32'(lat), 32'd3);
        chk("t5_reissue_rdata",   32'(cpu_rdata), 32'hC3);
        cpu_req = 1'b0;
        step();

        // Rendering stream with a pending CPU read
        render_active = 1'b1;
        cpu_issue(1'b0, 14'h3F00, 8'h00);
        fork
            begin
                render_stream(6, 1'b0);
                #4;
                render_active = 1'b0;
            end
            begin
                int n     = 0;
                int after = 0;
                bit during = 1'b0;
                while (n < 80) begin
                    if (!render_active) after++;
                    step();
                    n++;
                    if (cpu_ack) begin
                        during = render_active;
                        break;
                    end
                end
                chk("t6_cpu_ack_seen", 32'(cpu_ack), 32'd1);
                cpu_req = 1'b0;
`ifdef PPU_ARB_RENDER_LOCK_EN
                chk("t6_no_grant_while_active", 32'(during), 32'd0);
                chk("t6_ack_after_fall_le4",    32'(after <= 4), 32'd1);
`else
                chk("t6_served_in_gap", 32'(during), 32'd1);
`endif
            end
        join
        render_active = 1'b0;
        step();

        // Randomized concurrent traffic (render region 0x0000-0x1FFF, CPU region 0x2000-0x3FFF)
        fork
            render_stream(40, 1'b1);
            cpu_stream(40);
        join

        repeat (6) step();
        chk("render_queue_drained", 32'(render_q.size()), 32'd0);
        chk("cpu_queue_drained",    32'(cpu_q.size()),    32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
